// File: rtl/pipe_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_share_pkg
// Description : Shared types for the two-requester pipeline sharing block.
//               req_id_t names the requester that owns a transfer; tag_t is
//               one stage of the shadow pipeline that carries that ownership
//               alongside the data.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_share_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

    localparam tag_t c_tag_idle = '{vld: 1'b0, id: REQ_A};

endpackage : pipe_share_pkg
`default_nettype wire

// File: rtl/pipe_share_arbiter_tag_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tag_delay_line
// Description : DEPTH-stage register chain of tag_t. It runs in lock-step
//               with the shared datapath pipeline, so the tag leaving the
//               last stage describes the result currently on pipe_out_*.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous active-low reset, clears every stage
//               tag_in  - tag of the transfer issued this cycle
//               tag_out - tag aligned with the pipeline output
// Revision    : 1.0 - initial release
// ============================================================================
module tag_delay_line
    import pipe_share_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t r_stage [DEPTH];

    // Stages shift unconditionally: the datapath pipeline never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= c_tag_idle;
            end
        end else begin
            r_stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign tag_out = r_stage[DEPTH-1];

endmodule : tag_delay_line
`default_nettype wire

// File: rtl/pipe_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_share_arbiter
// Description : Shares one fixed-latency, no-stall pipeline between
//               requesters A and B. Per-cycle round-robin arbitration with a
//               per-requester in-flight credit limit; a shadow tag pipeline
//               steers each result back to the requester that issued it.
// Ports       : clk, rst                  - clock; async active-low reset
//               a_vld/a_data/a_rdy        - requester A issue handshake
//               b_vld/b_data/b_rdy        - requester B issue handshake
//               pipe_in_vld/pipe_in_data  - to the shared pipeline input
//               pipe_out_vld/pipe_out_data- from the shared pipeline output
//               a_out_vld/a_out_data      - results for A (no backpressure)
//               b_out_vld/b_out_data      - results for B (no backpressure)
//               tag_err                   - sticky pipeline/tag valid mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_share_arbiter
    import pipe_share_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_vld,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_rdy,
    input  logic             b_vld,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_rdy,
    output logic             pipe_in_vld,
    output logic [WIDTH-1:0] pipe_in_data,
    input  logic             pipe_out_vld,
    input  logic [WIDTH-1:0] pipe_out_data,
    output logic             a_out_vld,
    output logic [WIDTH-1:0] a_out_data,
    output logic             b_out_vld,
    output logic [WIDTH-1:0] b_out_data,
    output logic             tag_err
);

    localparam int c_cnt_w = $clog2(MAX_INFLIGHT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_INFLIGHT);

    logic [c_cnt_w-1:0] r_cnt_a;
    logic [c_cnt_w-1:0] r_cnt_b;
    req_id_t            r_last_grant;
    logic               r_tag_err;

    logic    w_elig_a;
    logic    w_elig_b;
    logic    w_take_a;
    logic    w_take_b;
    req_id_t w_grant_id;
    tag_t    w_tag_in;
    tag_t    w_tag_out;
    logic    w_ret_a;
    logic    w_ret_b;

    // ------------------------------------------------------------------
    // Arbitration. Eligibility uses the registered counters, so a credit
    // returned this cycle only becomes usable next cycle. rst gates the
    // ready outputs so nothing is offered while reset is asserted.
    // ------------------------------------------------------------------
    assign w_elig_a = (r_cnt_a != c_cnt_max);
    assign w_elig_b = (r_cnt_b != c_cnt_max);

    assign a_rdy = rst & w_elig_a & (~b_vld | ~w_elig_b | (r_last_grant == REQ_B));
    assign b_rdy = rst & w_elig_b & (~a_vld | ~w_elig_a | (r_last_grant == REQ_A));

    assign w_take_a = a_vld & a_rdy;
    assign w_take_b = b_vld & b_rdy;

    assign pipe_in_vld  = w_take_a | w_take_b;
    assign pipe_in_data = w_take_a ? a_data : (w_take_b ? b_data : '0);
    assign w_grant_id   = w_take_b ? REQ_B : REQ_A;

    assign w_tag_in = '{vld: pipe_in_vld, id: w_grant_id};

    tag_delay_line #(
        .DEPTH (DEPTH)
    ) u_tag_delay_line (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_out)
    );

    // ------------------------------------------------------------------
    // Return steering. Credits are released from the tag alone, so a
    // pipeline that drops or invents a valid cannot leak or mint credits;
    // the result itself is only forwarded when both valids agree.
    // ------------------------------------------------------------------
    assign w_ret_a = w_tag_out.vld & (w_tag_out.id == REQ_A);
    assign w_ret_b = w_tag_out.vld & (w_tag_out.id == REQ_B);

    assign a_out_vld  = w_ret_a & pipe_out_vld;
    assign b_out_vld  = w_ret_b & pipe_out_vld;
    assign a_out_data = a_out_vld ? pipe_out_data : '0;
    assign b_out_data = b_out_vld ? pipe_out_data : '0;
    assign tag_err    = r_tag_err;

    function automatic logic [c_cnt_w-1:0] f_next_cnt(
        input logic [c_cnt_w-1:0] cnt,
        input logic               inc,
        input logic               dec
    );
        logic [c_cnt_w-1:0] nxt;
        nxt = cnt;
        case ({inc, dec})
            2'b10:   if (cnt != c_cnt_max) nxt = cnt + 1'b1;
            2'b01:   if (cnt != '0)        nxt = cnt - 1'b1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_a      <= '0;
            r_cnt_b      <= '0;
            r_last_grant <= REQ_B;
            r_tag_err    <= 1'b0;
        end else begin
            r_cnt_a <= f_next_cnt(r_cnt_a, w_take_a, w_ret_a);
            r_cnt_b <= f_next_cnt(r_cnt_b, w_take_b, w_ret_b);
            if (w_take_a) begin
                r_last_grant <= REQ_A;
            end else if (w_take_b) begin
                r_last_grant <= REQ_B;
            end
            if (w_tag_out.vld != pipe_out_vld) begin
                r_tag_err <= 1'b1;
            end
        end
    end

endmodule : pipe_share_arbiter
`default_nettype wire

// File: tb/tb_pipe_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_share_arbiter
// Description : Directed self-checking bench. Three instances share clk/rst:
//               dut0 (depth 8, 4 credits), dut1 (depth 8, 2 credits) and
//               dut2 (depth 2, 1 credit), each attached to its own
//               shift-register pipeline model reset by the same rst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic force_vld = 1'b0;

    // ---------------- dut0 : depth 8, max_inflight 4 ----------------
    logic       a_vld0 = 0, b_vld0 = 0;
    logic [7:0] a_data0 = 0, b_data0 = 0;
    logic       a_rdy0, b_rdy0, pin_vld0, pout_vld0;
    logic [7:0] pin_data0, pout_data0;
    logic       a_out_vld0, b_out_vld0, tag_err0;
    logic [7:0] a_out_data0, b_out_data0;
    logic [8:0] pm0 [8];

    // ---------------- dut1 : depth 8, max_inflight 2 ----------------
    logic       a_vld1 = 0, b_vld1 = 0;
    logic [7:0] a_data1 = 0, b_data1 = 0;
    logic       a_rdy1, b_rdy1, pin_vld1, pout_vld1;
    logic [7:0] pin_data1, pout_data1;
    logic       a_out_vld1, b_out_vld1, tag_err1;
    logic [7:0] a_out_data1, b_out_data1;
    logic [8:0] pm1 [8];

    // ---------------- dut2 : depth 2, max_inflight 1 ----------------
    logic       a_vld2 = 0, b_vld2 = 0;
    logic [7:0] a_data2 = 0, b_data2 = 0;
    logic       a_rdy2, b_rdy2, pin_vld2, pout_vld2;
    logic [7:0] pin_data2, pout_data2;
    logic       a_out_vld2, b_out_vld2, tag_err2;
    logic [7:0] a_out_data2, b_out_data2;
    logic [8:0] pm2 [2];

    // Attached pipeline models (shift_register_with_valid behaviour).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) pm0[i] <= '0;
            for (int i = 0; i < 8; i++) pm1[i] <= '0;
            for (int i = 0; i < 2; i++) pm2[i] <= '0;
        end else begin
            pm0[0] <= {pin_vld0, pin_data0};
            pm1[0] <= {pin_vld1, pin_data1};
            pm2[0] <= {pin_vld2, pin_data2};
            for (int i = 1; i < 8; i++) pm0[i] <= pm0[i-1];
            for (int i = 1; i < 8; i++) pm1[i] <= pm1[i-1];
            pm2[1] <= pm2[0];
        end
    end

    assign pout_vld0  = pm0[7][8] | force_vld;
    assign pout_data0 = pm0[7][7:0];
    assign pout_vld1  = pm1[7][8];
    assign pout_data1 = pm1[7][7:0];
    assign pout_vld2  = pm2[1][8];
    assign pout_data2 = pm2[1][7:0];

    pipe_share_arbiter #(.WIDTH(8), .DEPTH(8), .MAX_INFLIGHT(4)) dut0 (
        .clk(clk), .rst(rst),
        .a_vld(a_vld0), .a_data(a_data0), .a_rdy(a_rdy0),
        .b_vld(b_vld0), .b_data(b_data0), .b_rdy(b_rdy0),
        .pipe_in_vld(pin_vld0), .pipe_in_data(pin_data0),
        .pipe_out_vld(pout_vld0), .pipe_out_data(pout_data0),
        .a_out_vld(a_out_vld0), .a_out_data(a_out_data0),
        .b_out_vld(b_out_vld0), .b_out_data(b_out_data0),
        .tag_err(tag_err0)
    );

    pipe_share_arbiter #(.WIDTH(8), .DEPTH(8), .MAX_INFLIGHT(2)) dut1 (
        .clk(clk), .rst(rst),
        .a_vld(a_vld1), .a_data(a_data1), .a_rdy(a_rdy1),
        .b_vld(b_vld1), .b_data(b_data1), .b_rdy(b_rdy1),
        .pipe_in_vld(pin_vld1), .pipe_in_data(pin_data1),
        .pipe_out_vld(pout_vld1), .pipe_out_data(pout_data1),
        .a_out_vld(a_out_vld1), .a_out_data(a_out_data1),
        .b_out_vld(b_out_vld1), .b_out_data(b_out_data1),
        .tag_err(tag_err1)
    );

    pipe_share_arbiter #(.WIDTH(8), .DEPTH(2), .MAX_INFLIGHT(1)) dut2 (
        .clk(clk), .rst(rst),
        .a_vld(a_vld2), .a_data(a_data2), .a_rdy(a_rdy2),
        .b_vld(b_vld2), .b_data(b_data2), .b_rdy(b_rdy2),
        .pipe_in_vld(pin_vld2), .pipe_in_data(pin_data2),
        .pipe_out_vld(pout_vld2), .pipe_out_data(pout_data2),
        .a_out_vld(a_out_vld2), .a_out_data(a_out_data2),
        .b_out_vld(b_out_vld2), .b_out_data(b_out_data2),
        .tag_err(tag_err2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic reset_all();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;

        // ---------------- reset state ----------------
        @(posedge clk);
        #1;
        a_vld0 = 1'b1;
        b_vld0 = 1'b1;
        #1;
        check_eq("rst a_rdy", a_rdy0, 0);
        check_eq("rst b_rdy", b_rdy0, 0);
        check_eq("rst pipe_in_vld", pin_vld0, 0);
        check_eq("rst pipe_in_data", pin_data0, 0);
        check_eq("rst a_out_vld", a_out_vld0, 0);
        check_eq("rst b_out_vld", b_out_vld0, 0);
        check_eq("rst tag_err", tag_err0, 0);
        a_vld0 = 1'b0;
        b_vld0 = 1'b0;
        next_cycle();
        rst = 1'b1;

        // ---------------- 1: single A transfer ----------------
        a_vld0 = 1'b1;
        a_data0 = 8'h3C;
        @(negedge clk);
        check_eq("t1 a_rdy", a_rdy0, 1);
        check_eq("t1 pipe_in_vld", pin_vld0, 1);
        check_eq("t1 pipe_in_data", pin_data0, 8'h3C);
        next_cycle();
        a_vld0 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_eq($sformatf("t1 a_out_vld c%0d", c), a_out_vld0, (c == 8));
            check_eq($sformatf("t1 a_out_data c%0d", c), a_out_data0, (c == 8) ? 8'h3C : 8'h00);
            check_eq($sformatf("t1 b_out_vld c%0d", c), b_out_vld0, 0);
            next_cycle();
        end

        // ---------------- 2: contention, alternating grants ----------------
        reset_all();
        for (int c = 0; c < 16; c++) begin
            a_vld0  = (c < 6);
            b_vld0  = (c < 6);
            a_data0 = 8'h10 + 8'(c);
            b_data0 = 8'h20 + 8'(c);
            @(negedge clk);
            if (c < 6) begin
                check_eq($sformatf("t2 a_rdy c%0d", c), a_rdy0, (c % 2 == 0));
                check_eq($sformatf("t2 b_rdy c%0d", c), b_rdy0, (c % 2 == 1));
                exp_d = (c % 2 == 0) ? 8'h10 + 8'(c) : 8'h20 + 8'(c);
                check_eq($sformatf("t2 pipe_in_data c%0d", c), pin_data0, exp_d);
            end
            if (c >= 8 && c < 14) begin
                check_eq($sformatf("t2 a_out_vld c%0d", c), a_out_vld0, (c % 2 == 0));
                check_eq($sformatf("t2 b_out_vld c%0d", c), b_out_vld0, (c % 2 == 1));
                check_eq($sformatf("t2 a_out_data c%0d", c), a_out_data0,
                         (c % 2 == 0) ? 8'h10 + 8'(c - 8) : 8'h00);
                check_eq($sformatf("t2 b_out_data c%0d", c), b_out_data0,
                         (c % 2 == 1) ? 8'h20 + 8'(c - 8) : 8'h00);
            end else begin
                check_eq($sformatf("t2 a_out_vld idle c%0d", c), a_out_vld0, 0);
                check_eq($sformatf("t2 b_out_vld idle c%0d", c), b_out_vld0, 0);
            end
            next_cycle();
        end

        // ---------------- 3: credit limit 2, depth 8 ----------------
        reset_all();
        a_vld1 = 1'b1;
        for (int c = 0; c < 13; c++) begin
            a_data1 = 8'h50 + 8'(c);
            @(negedge clk);
            check_eq($sformatf("t3 a_rdy c%0d", c), a_rdy1, (c < 2 || c == 9 || c == 10));
            check_eq($sformatf("t3 a_out_vld c%0d", c), a_out_vld1, (c == 8 || c == 9));
            exp_d = (c == 8) ? 8'h50 : ((c == 9) ? 8'h51 : 8'h00);
            check_eq($sformatf("t3 a_out_data c%0d", c), a_out_data1, exp_d);
            next_cycle();
        end
        a_vld1 = 1'b0;

        // ---------------- 4: credit recycle 1, depth 2 ----------------
        reset_all();
        a_vld2 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a_data2 = 8'h60 + 8'(c);
            @(negedge clk);
            check_eq($sformatf("t4 a_rdy c%0d", c), a_rdy2, (c % 3 == 0));
            check_eq($sformatf("t4 a_out_vld c%0d", c), a_out_vld2, (c >= 2 && c % 3 == 2));
            exp_d = (c >= 2 && c % 3 == 2) ? 8'h60 + 8'(c - 2) : 8'h00;
            check_eq($sformatf("t4 a_out_data c%0d", c), a_out_data2, exp_d);
            next_cycle();
        end
        a_vld2 = 1'b0;

        // ---------------- 5: reset mid-flight ----------------
        reset_all();
        for (int c = 0; c < 5; c++) begin
            a_vld0  = 1'b1;
            b_vld0  = 1'b1;
            a_data0 = 8'h70 + 8'(c);
            b_data0 = 8'h80 + 8'(c);
            @(negedge clk);
            check_eq($sformatf("t5 a_rdy c%0d", c), a_rdy0, (c % 2 == 0));
            next_cycle();
        end
        rst = 1'b0;
        #1;
        check_eq("t5 rst a_rdy", a_rdy0, 0);
        check_eq("t5 rst b_rdy", b_rdy0, 0);
        check_eq("t5 rst pipe_in_vld", pin_vld0, 0);
        check_eq("t5 rst a_out_vld", a_out_vld0, 0);
        check_eq("t5 rst b_out_vld", b_out_vld0, 0);
        next_cycle();
        rst = 1'b1;
        a_vld0 = 1'b0;
        b_vld0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("t5 a_out_vld c%0d", c), a_out_vld0, 0);
            check_eq($sformatf("t5 b_out_vld c%0d", c), b_out_vld0, 0);
            check_eq($sformatf("t5 tag_err c%0d", c), tag_err0, 0);
            next_cycle();
        end
        a_vld0 = 1'b1;
        b_vld0 = 1'b1;
        @(negedge clk);
        check_eq("t5 tie a_rdy", a_rdy0, 1);
        check_eq("t5 tie b_rdy", b_rdy0, 0);
        next_cycle();
        a_vld0 = 1'b0;
        b_vld0 = 1'b0;

        // ---------------- 6: tag error ----------------
        reset_all();
        force_vld = 1'b1;
        @(negedge clk);
        check_eq("t6 tag_err before edge", tag_err0, 0);
        check_eq("t6 a_out_vld", a_out_vld0, 0);
        check_eq("t6 b_out_vld", b_out_vld0, 0);
        next_cycle();
        force_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("t6 tag_err sticky c%0d", c), tag_err0, 1);
            check_eq($sformatf("t6 a_out_vld c%0d", c), a_out_vld0, 0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_share_arbiter
`default_nettype wire
